// File: rtl/bsg_cache_sbuf_drain_ctrl.sv
// bsg_cache_sbuf_drain_ctrl
//
// Purpose: decides, every cycle, whether the single-ported data memory
// serves a pipeline load or retires the head store-buffer entry. Loads
// normally win. A starvation counter forces a store drain after a bounded
// wait. A flush request blocks loads until the store buffer is empty.
//
// Optional feature macro: BSG_CACHE_SBUF_DRAIN_STARVE_EN
//   defined   : starvation override active (stall_cnt_r is built)
//   undefined : loads always win in IDLE; stores drain only when no load
//               is requesting, or during FLUSH
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   sbuf_v_i         head entry valid
//   sbuf_entry_i     head entry {addr, data, byte mask, way}
//   sbuf_empty_i     store buffer empty
//   sbuf_yumi_o      head entry consumed this cycle
//   ld_v_i           load requests dmem
//   ld_grant_o       load owns dmem this cycle
//   flush_v_i        drain-all request (level, sampled in IDLE)
//   flush_done_o     one-cycle pulse on flush completion
//   dmem_v_o         dmem store access
//   dmem_addr_o      dmem row index
//   dmem_data_o      entry data replicated to every way lane
//   dmem_w_mask_o    entry byte mask placed in the entry's way lane
module bsg_cache_sbuf_drain_ctrl #(
  parameter int addr_width_p    = 28,
  parameter int data_width_p    = 32,
  parameter int ways_p          = 4,
  parameter int lg_sets_p       = 6,
  parameter int lg_block_size_p = 3,
  parameter int max_stall_p     = 7,
  localparam int way_width_lp   = (ways_p > 1) ? $clog2(ways_p) : 1,
  localparam int mask_width_lp  = data_width_p / 8,
  localparam int row_width_lp   = lg_sets_p + lg_block_size_p,
  localparam int entry_width_lp = addr_width_p + data_width_p + mask_width_lp + way_width_lp
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                sbuf_v_i,
  input  logic [entry_width_lp-1:0]           sbuf_entry_i,
  input  logic                                sbuf_empty_i,
  output logic                                sbuf_yumi_o,
  input  logic                                ld_v_i,
  output logic                                ld_grant_o,
  input  logic                                flush_v_i,
  output logic                                flush_done_o,
  output logic                                dmem_v_o,
  output logic [row_width_lp-1:0]             dmem_addr_o,
  output logic [ways_p*data_width_p-1:0]      dmem_data_o,
  output logic [ways_p*mask_width_lp-1:0]     dmem_w_mask_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e state_r, state_n;
  logic   drain_s, grant_s, done_s, starved_s;

  // entry field split
  logic [way_width_lp-1:0]  entry_way_s;
  logic [mask_width_lp-1:0] entry_mask_s;
  logic [data_width_p-1:0]  entry_data_s;
  logic [addr_width_p-1:0]  entry_addr_s;

  assign entry_way_s  = sbuf_entry_i[way_width_lp-1:0];
  assign entry_mask_s = sbuf_entry_i[way_width_lp +: mask_width_lp];
  assign entry_data_s = sbuf_entry_i[way_width_lp+mask_width_lp +: data_width_p];
  assign entry_addr_s = sbuf_entry_i[entry_width_lp-1 -: addr_width_p];

  // byte-offset bits and tag bits do not reach the row index
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{entry_addr_s[addr_width_p-1:row_width_lp+2], entry_addr_s[1:0]};

`ifdef BSG_CACHE_SBUF_DRAIN_STARVE_EN
  localparam int cnt_width_lp = $clog2(max_stall_p + 1);

  logic [cnt_width_lp-1:0] stall_cnt_r, stall_cnt_n;

  assign starved_s = (stall_cnt_r == cnt_width_lp'(max_stall_p));

  // Counts consecutive IDLE cycles in which a valid head lost to a load.
  // Any drain, an empty head, or FLUSH resets it.
  always_comb begin
    stall_cnt_n = {cnt_width_lp{1'b0}};
    if ((state_r == IDLE) && sbuf_v_i && !drain_s) begin
      if (starved_s) begin
        stall_cnt_n = stall_cnt_r;
      end else begin
        stall_cnt_n = stall_cnt_r + {{(cnt_width_lp-1){1'b0}}, 1'b1};
      end
    end else begin
      stall_cnt_n = {cnt_width_lp{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_r <= {cnt_width_lp{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_n;
    end
  end
`else
  assign starved_s = 1'b0;
`endif

  // Arbitration and next-state. Reset forces every decision to 0.
  always_comb begin
    state_n = state_r;
    drain_s = 1'b0;
    grant_s = 1'b0;
    done_s  = 1'b0;
    if (reset_i) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (ld_v_i && !starved_s) begin
            grant_s = 1'b1;
          end else if (sbuf_v_i) begin
            drain_s = 1'b1;
          end else begin
            drain_s = 1'b0;
          end
          // the request cycle itself still arbitrates as IDLE
          if (flush_v_i) begin
            state_n = FLUSH;
          end else begin
            state_n = IDLE;
          end
        end
        FLUSH: begin
          drain_s = sbuf_v_i;
          // empty with a valid head is a pass-through entry: keep draining
          if (sbuf_empty_i && !sbuf_v_i) begin
            done_s  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = FLUSH;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  assign sbuf_yumi_o  = drain_s;
  assign dmem_v_o     = drain_s;
  assign ld_grant_o   = grant_s;
  assign flush_done_o = done_s;

  assign dmem_addr_o = drain_s ? entry_addr_s[row_width_lp+1:2] : {row_width_lp{1'b0}};
  assign dmem_data_o = drain_s ? {ways_p{entry_data_s}} : {(ways_p*data_width_p){1'b0}};

  // Byte mask lands only in the lane of the entry's way.
  always_comb begin
    dmem_w_mask_o = {(ways_p*mask_width_lp){1'b0}};
    for (int i = 0; i < ways_p; i++) begin
      if (drain_s && (entry_way_s == way_width_lp'(i))) begin
        dmem_w_mask_o[i*mask_width_lp +: mask_width_lp] = entry_mask_s;
      end else begin
        dmem_w_mask_o[i*mask_width_lp +: mask_width_lp] = {mask_width_lp{1'b0}};
      end
    end
  end

endmodule
